toggle_activity_monitor: RTL and testbench

//  Consumer side of the counter/activity path. Samples a WIDTH-bit bus every enabled clock.

---
 rtl/toggle_activity_monitor.sv | 185 ++++++++++++++++++
 tb/tb_toggle_activity_monitor.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/toggle_activity_monitor.sv
// rtl/toggle_activity_monitor.sv - windowed bit-toggle counter with single-entry valid/ready report
// Optional per-bit toggle counters are compiled in with PER_BIT_STATS_EN.
module toggle_activity_monitor #(
  parameter int WIDTH  = 4,
  parameter int WINDOW = 16,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [WIDTH-1:0]       sig_in,
  output logic                   rpt_valid,
  input  logic                   rpt_ready,
  output logic [CNT_W-1:0]       rpt_toggles,
  output logic [7:0]             rpt_window_id,
  output logic                   rpt_saturated,
  output logic                   rpt_dropped
`ifdef PER_BIT_STATS_EN
  ,
  output logic [WIDTH*CNT_W-1:0] rpt_bit_toggles
`endif
);

  localparam int WIN_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam int SUM_W = ((CNT_W > 6) ? CNT_W : 6) + 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [SUM_W-1:0] SUM_MAX  = SUM_W'(CNT_MAX);

  typedef enum logic {PRIME = 1'b0, ACCUM = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [7:0]       win_id_q, win_id_d;

  logic             rpt_valid_q, rpt_valid_d;
  logic [CNT_W-1:0] rpt_toggles_q, rpt_toggles_d;
  logic [7:0]       rpt_id_q, rpt_id_d;
  logic             rpt_sat_q, rpt_sat_d;
  logic             rpt_drop_q, rpt_drop_d;

  logic             prime_load, accum_en, win_end, win_clr;
  logic             accept, load, drop;
  logic [WIDTH-1:0] toggles;
  logic [5:0]       d;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] acc_new;
  logic             sat_new;
  logic             bit_sat_any;

  function automatic logic [5:0] popcount(input logic [WIDTH-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + 6'(v[i]);
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= PRIME;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PRIME:   if (en)  state_d = ACCUM;
      ACCUM:   if (!en) state_d = PRIME;
      default: state_d = PRIME;
    endcase
  end

  // win_clr covers both a completed window and an abandoned partial one
  always_comb begin
    prime_load = (state_q == PRIME) && en;
    accum_en   = (state_q == ACCUM) && en;
    win_end    = accum_en && (win_cnt_q == WIN_LAST);
    win_clr    = (state_q == ACCUM) && (!en || (win_cnt_q == WIN_LAST));
  end

  always_comb begin
    toggles = sig_in ^ prev_q;
    d       = popcount(toggles);
    sum     = SUM_W'(acc_q) + SUM_W'(d);
    acc_new = (sum > SUM_MAX) ? CNT_MAX : sum[CNT_W-1:0];
    sat_new = sat_q || (acc_new == CNT_MAX) || bit_sat_any;

    prev_d    = prev_q;
    acc_d     = acc_q;
    sat_d     = sat_q;
    win_cnt_d = win_cnt_q;
    win_id_d  = win_id_q;
    if (prime_load || accum_en) prev_d = sig_in;
    if (win_clr) begin
      acc_d     = '0;
      sat_d     = 1'b0;
      win_cnt_d = '0;
    end else if (accum_en) begin
      acc_d     = acc_new;
      sat_d     = sat_new;
      win_cnt_d = win_cnt_q + WIN_W'(1);
    end
    if (win_end) win_id_d = win_id_q + 8'd1;
  end

  always_comb begin
    accept = rpt_valid_q && rpt_ready;
    load   = win_end && (!rpt_valid_q || rpt_ready);
    drop   = win_end && rpt_valid_q && !rpt_ready;

    rpt_valid_d   = load ? 1'b1 : (accept ? 1'b0 : rpt_valid_q);
    rpt_toggles_d = load ? acc_new  : rpt_toggles_q;
    rpt_id_d      = load ? win_id_q : rpt_id_q;
    rpt_sat_d     = load ? sat_new  : rpt_sat_q;
    rpt_drop_d    = drop ? 1'b1 : (accept ? 1'b0 : rpt_drop_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q        <= '0;
      acc_q         <= '0;
      sat_q         <= 1'b0;
      win_cnt_q     <= '0;
      win_id_q      <= '0;
      rpt_valid_q   <= 1'b0;
      rpt_toggles_q <= '0;
      rpt_id_q      <= '0;
      rpt_sat_q     <= 1'b0;
      rpt_drop_q    <= 1'b0;
    end else begin
      prev_q        <= prev_d;
      acc_q         <= acc_d;
      sat_q         <= sat_d;
      win_cnt_q     <= win_cnt_d;
      win_id_q      <= win_id_d;
      rpt_valid_q   <= rpt_valid_d;
      rpt_toggles_q <= rpt_toggles_d;
      rpt_id_q      <= rpt_id_d;
      rpt_sat_q     <= rpt_sat_d;
      rpt_drop_q    <= rpt_drop_d;
    end
  end

`ifdef PER_BIT_STATS_EN
  logic [CNT_W-1:0]       bit_acc_q [WIDTH];
  logic [CNT_W-1:0]       bit_acc_d [WIDTH];
  logic [CNT_W-1:0]       bit_new   [WIDTH];
  logic [WIDTH*CNT_W-1:0] rpt_bits_q, rpt_bits_d;

  // a per-bit counter that reaches all-ones stays there, so hitting max is its sticky flag
  always_comb begin
    bit_sat_any = 1'b0;
    rpt_bits_d  = rpt_bits_q;
    for (int i = 0; i < WIDTH; i++) begin
      bit_new[i]   = (bit_acc_q[i] == CNT_MAX) ? CNT_MAX : bit_acc_q[i] + CNT_W'(toggles[i]);
      bit_sat_any  = bit_sat_any || (bit_new[i] == CNT_MAX);
      bit_acc_d[i] = win_clr ? '0 : (accum_en ? bit_new[i] : bit_acc_q[i]);
      if (load) rpt_bits_d[i*CNT_W +: CNT_W] = bit_new[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) bit_acc_q[i] <= '0;
      rpt_bits_q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) bit_acc_q[i] <= bit_acc_d[i];
      rpt_bits_q <= rpt_bits_d;
    end
  end

  assign rpt_bit_toggles = rpt_bits_q;
`else
  assign bit_sat_any = 1'b0;
`endif

  assign rpt_valid     = rpt_valid_q;
  assign rpt_toggles   = rpt_toggles_q;
  assign rpt_window_id = rpt_id_q;
  assign rpt_saturated = rpt_sat_q;
  assign rpt_dropped   = rpt_drop_q;

endmodule

// File: tb/tb_toggle_activity_monitor.sv
// tb/tb_toggle_activity_monitor.sv - directed bench for toggle_activity_monitor (16-bit and 4-bit counters)
module tb_toggle_activity_monitor;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [3:0]  sig_in;
  logic        rpt_ready;

  logic        rpt_valid;
  logic [15:0] rpt_toggles;
  logic [7:0]  rpt_window_id;
  logic        rpt_saturated;
  logic        rpt_dropped;

  logic        s_valid;
  logic [3:0]  s_toggles;
  logic [7:0]  s_window_id;
  logic        s_saturated;
  logic        s_dropped;

`ifdef PER_BIT_STATS_EN
  logic [63:0] rpt_bit_toggles;
  logic [15:0] s_bit_toggles;
`endif

  int n_checks = 0;
  int n_err    = 0;

  toggle_activity_monitor #(.WIDTH(4), .WINDOW(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_toggles(rpt_toggles),
    .rpt_window_id(rpt_window_id), .rpt_saturated(rpt_saturated), .rpt_dropped(rpt_dropped)
`ifdef PER_BIT_STATS_EN
    , .rpt_bit_toggles(rpt_bit_toggles)
`endif
  );

  toggle_activity_monitor #(.WIDTH(4), .WINDOW(16), .CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
    .rpt_valid(s_valid), .rpt_ready(rpt_ready), .rpt_toggles(s_toggles),
    .rpt_window_id(s_window_id), .rpt_saturated(s_saturated), .rpt_dropped(s_dropped)
`ifdef PER_BIT_STATS_EN
    , .rpt_bit_toggles(s_bit_toggles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic e, input logic [3:0] s);
    en     = e;
    sig_in = s;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(rpt_valid), 0);
    check({tag, "_toggles"}, 32'(rpt_toggles), 0);
    check({tag, "_id"}, 32'(rpt_window_id), 0);
    check({tag, "_sat"}, 32'(rpt_saturated), 0);
    check({tag, "_dropped"}, 32'(rpt_dropped), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    sig_in    = 4'h0;
    rpt_ready = 1'b1;
    tick(0, 4'h0);
    tick(0, 4'h0);
    check_all_zero("reset");
    rst_n = 1'b1;

    // free-running counter: 16+8+4+2 toggles per window
    tick(1, 4'h0);
    for (int w = 0; w < 3; w++) begin
      for (int k = 1; k <= 16; k++) begin
        tick(1, 4'(k));
        if (k == 1 && w > 0) check("t1_valid_fall", 32'(rpt_valid), 0);
        if (k == 15) check("t1_latency", 32'(rpt_valid), 0);
      end
      check("t1_valid", 32'(rpt_valid), 1);
      check("t1_toggles", 32'(rpt_toggles), 30);
      check("t1_id", 32'(rpt_window_id), 32'(w));
      check("t1_dropped", 32'(rpt_dropped), 0);
      check("t1_sat", 32'(rpt_saturated), 0);
`ifdef PER_BIT_STATS_EN
      check("t1_bit0", 32'(rpt_bit_toggles[15:0]), 16);
      check("t1_bit1", 32'(rpt_bit_toggles[31:16]), 8);
      check("t1_bit2", 32'(rpt_bit_toggles[47:32]), 4);
      check("t1_bit3", 32'(rpt_bit_toggles[63:48]), 2);
`endif
    end

    // constant bus, then full-swing alternation (also saturates the 4-bit instance)
    rst_n = 1'b0;
    tick(0, 4'h0);
    rst_n = 1'b1;
    tick(1, 4'hA);
    for (int w = 0; w < 2; w++) begin
      for (int k = 1; k <= 16; k++) tick(1, 4'hA);
      check("t2_const_toggles", 32'(rpt_toggles), 0);
      check("t2_const_id", 32'(rpt_window_id), 32'(w));
      check("t2_small_const", 32'(s_toggles), 0);
      check("t2_small_const_sat", 32'(s_saturated), 0);
    end
    tick(0, 4'hA);
    tick(1, 4'hF);
    for (int k = 1; k <= 16; k++) tick(1, k[0] ? 4'h0 : 4'hF);
    check("t2_alt_toggles", 32'(rpt_toggles), 64);
    check("t2_alt_id", 32'(rpt_window_id), 2);
    check("t2_alt_sat", 32'(rpt_saturated), 0);
    check("t4_small_valid", 32'(s_valid), 1);
    check("t4_small_id", 32'(s_window_id), 2);
    check("t4_small_toggles", 32'(s_toggles), 15);
    check("t4_small_sat", 32'(s_saturated), 1);
    for (int k = 1; k <= 16; k++) tick(1, 4'hF);
    check("t2_quiet_toggles", 32'(rpt_toggles), 0);
    check("t2_quiet_id", 32'(rpt_window_id), 3);
    check("t4_small_clear_toggles", 32'(s_toggles), 0);
    check("t4_small_clear_sat", 32'(s_saturated), 0);
    check("t4_small_dropped", 32'(s_dropped), 0);

    // backpressure over window ends 3,4,5: report 3 held, 4 and 5 dropped
    rpt_ready = 1'b0;
    for (int k = 1; k <= 16; k++) tick(1, k[0] ? 4'h0 : 4'hF);
    check("t3_held_valid", 32'(rpt_valid), 1);
    check("t3_held_id", 32'(rpt_window_id), 3);
    check("t3_held_toggles", 32'(rpt_toggles), 0);
    check("t3_dropped", 32'(rpt_dropped), 1);
    for (int k = 1; k <= 16; k++) tick(1, 4'hF);
    check("t3_held_id2", 32'(rpt_window_id), 3);
    check("t3_dropped2", 32'(rpt_dropped), 1);
    rpt_ready = 1'b1;
    tick(1, 4'hF);
    check("t3_accept_valid", 32'(rpt_valid), 0);
    check("t3_accept_dropped", 32'(rpt_dropped), 0);
    for (int k = 2; k <= 16; k++) tick(1, 4'hF);
    check("t3_next_valid", 32'(rpt_valid), 1);
    check("t3_next_id", 32'(rpt_window_id), 6);
    check("t3_next_dropped", 32'(rpt_dropped), 0);

    // reset at sample 9 of a window
    for (int k = 1; k <= 8; k++) tick(1, k[0] ? 4'h0 : 4'hF);
    rst_n = 1'b0;
    tick(1, 4'h0);
    check_all_zero("t5_reset");
    rst_n = 1'b1;
    tick(1, 4'h5);
    for (int k = 1; k <= 16; k++) tick(1, k[0] ? 4'h4 : 4'h5);
    check("t5_valid", 32'(rpt_valid), 1);
    check("t5_toggles", 32'(rpt_toggles), 16);
    check("t5_id", 32'(rpt_window_id), 0);

    // enable gap mid-window discards the partial window and re-primes
    for (int k = 1; k <= 5; k++) tick(1, k[0] ? 4'h4 : 4'h5);
    for (int k = 0; k < 5; k++) tick(0, 4'hF);
    check("t6_gap_valid", 32'(rpt_valid), 0);
    tick(1, 4'h5);
    for (int k = 1; k <= 16; k++) tick(1, 4'h6);
    check("t6_valid", 32'(rpt_valid), 1);
    check("t6_toggles", 32'(rpt_toggles), 2);
    check("t6_id", 32'(rpt_window_id), 1);
    check("t6_dropped", 32'(rpt_dropped), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
